// File: rtl/adxl362_host_pkg.sv
// Shared command codes, register map and state encodings for the ADXL362 host controller.
// Purely declarative: no logic, no latency, no flow control.
package adxl362_host_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_FIFO       = 8'h0D;

    localparam logic [7:0] XDATA_L        = 8'h0E;
    localparam logic [7:0] SOFT_RESET     = 8'h1F;
    localparam logic [7:0] INTMAP1        = 8'h2A;
    localparam logic [7:0] FILTER_CTL     = 8'h2C;
    localparam logic [7:0] POWER_CTL      = 8'h2D;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOFT_RST,
        ST_RST_WAIT,
        ST_CFG,
        ST_WAIT_INT,
        ST_READ,
        ST_PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_TAIL,
        TX_GAP
    } txn_t;

endpackage

// File: rtl/adxl362_spi_byte_master.sv
// SPI mode-0 byte shifter: one byte per start/done, 16*CLK_DIV clk per byte, MSB first.
// done is combinational on the last falling edge so a start in that cycle chains the next byte seamlessly.
module adxl362_spi_byte_master #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       active;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic       edge_due;

    assign edge_due = active && (div_cnt == DIV_LAST);
    assign done     = edge_due && sclk && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_byte <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (!active || done) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                tx_sh   <= tx_byte;
                mosi    <= tx_byte[7];
                bit_cnt <= '0;
            end else begin
                active  <= 1'b0;
                mosi    <= 1'b0;
            end
        end else if (edge_due) begin
            div_cnt <= '0;
            if (!sclk) begin
                // MISO is captured on the same clk edge that raises SCLK.
                sclk    <= 1'b1;
                rx_byte <= {rx_byte[6:0], miso};
            end else begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                mosi    <= tx_sh[6];
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adxl362_host_ctrl.sv
// ADXL362 host: soft-reset + 3 config writes, then one 8-byte burst read per INT1, publishing X/Y/Z with a 1-cycle strobe.
// Sole SPI master; no downstream backpressure, samples are overwritten if not consumed.
module adxl362_host_ctrl
    import adxl362_host_pkg::*;
#(
    parameter int         CLK_DIV        = 8,
    parameter int         CS_GAP         = 16,
    parameter logic [7:0] FILTER_CTL_VAL = 8'h13,
    parameter logic [7:0] INTMAP1_VAL    = 8'h01,
    parameter logic [7:0] POWER_CTL_VAL  = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        int1,
    input  logic        MISO,
    output logic        SCLK,
    output logic        MOSI,
    output logic        nCS,
    output logic [11:0] xdata,
    output logic [11:0] ydata,
    output logic [11:0] zdata,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy,
    output logic [15:0] sample_count
);

    localparam logic [15:0] TAIL_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [15:0] RST_WAIT_LAST = 16'(64 * CLK_DIV - 1);

    state_t      state, next_state;
    txn_t        ph;
    logic [15:0] cnt;
    logic [15:0] wait_cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  tx_idx;
    logic [2:0]  last_idx;
    logic [1:0]  cfg_idx;
    logic [1:0]  int1_sync;
    logic [11:0] acc_x, acc_y, acc_z;
    logic [7:0]  wr_addr, wr_data;
    logic [7:0]  spi_tx, spi_rx;
    logic        spi_start, spi_done;
    logic        txn_go, txn_end, txn_done, is_read;

    assign is_read  = (state == ST_READ);
    assign last_idx = is_read ? 3'd7 : 3'd2;
    assign txn_end  = (ph == TX_TAIL) && (cnt == '0);
    assign txn_done = (ph == TX_GAP) && (cnt == '0);
    assign busy     = !nCS || (ph == TX_GAP);

    adxl362_spi_byte_master #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (spi_start),
        .tx_byte (spi_tx),
        .done    (spi_done),
        .rx_byte (spi_rx),
        .sclk    (SCLK),
        .mosi    (MOSI),
        .miso    (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (enable && ph == TX_IDLE) next_state = ST_SOFT_RST;
            ST_SOFT_RST: if (txn_done) next_state = enable ? ST_RST_WAIT : ST_IDLE;
            ST_RST_WAIT: if (!enable) next_state = ST_IDLE;
                         else if (wait_cnt == '0) next_state = ST_CFG;
            ST_CFG:      if (txn_done) begin
                             if (!enable)             next_state = ST_IDLE;
                             else if (cfg_idx == 2'd2) next_state = ST_WAIT_INT;
                         end
            ST_WAIT_INT: if (!enable) next_state = ST_IDLE;
                         else if (int1_sync[1] && ph == TX_IDLE) next_state = ST_READ;
            ST_READ:     if (txn_end) next_state = ST_PUBLISH;
            ST_PUBLISH:  next_state = enable ? ST_WAIT_INT : ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        txn_go = (ph == TX_IDLE) &&
                 (state == ST_SOFT_RST || state == ST_CFG || state == ST_READ);
    end

    // Byte to present to the shifter: byte 0 on a fresh start, else the one after byte_idx.
    always_comb begin
        tx_idx  = (ph == TX_IDLE) ? 3'd0 : byte_idx + 3'd1;
        wr_addr = SOFT_RESET;
        wr_data = SOFT_RESET_KEY;
        if (state == ST_CFG) begin
            case (cfg_idx)
                2'd0:    begin wr_addr = FILTER_CTL; wr_data = FILTER_CTL_VAL; end
                2'd1:    begin wr_addr = INTMAP1;    wr_data = INTMAP1_VAL;    end
                default: begin wr_addr = POWER_CTL;  wr_data = POWER_CTL_VAL;  end
            endcase
        end
        case (tx_idx)
            3'd0:    spi_tx = is_read ? CMD_READ : CMD_WRITE;
            3'd1:    spi_tx = is_read ? XDATA_L : wr_addr;
            3'd2:    spi_tx = is_read ? 8'h00 : wr_data;
            default: spi_tx = 8'h00;
        endcase
        spi_start = ((ph == TX_IDLE) && txn_go) ||
                    ((ph == TX_SHIFT) && spi_done && (byte_idx != last_idx));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= TX_IDLE;
            nCS      <= 1'b1;
            cnt      <= '0;
            byte_idx <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
        end else begin
            case (ph)
                TX_IDLE: if (txn_go) begin
                    ph       <= TX_SHIFT;
                    nCS      <= 1'b0;
                    byte_idx <= '0;
                end
                TX_SHIFT: if (spi_done) begin
                    if (is_read) begin
                        case (byte_idx)
                            3'd2:    acc_x[7:0]  <= spi_rx;
                            3'd3:    acc_x[11:8] <= spi_rx[3:0];
                            3'd4:    acc_y[7:0]  <= spi_rx;
                            3'd5:    acc_y[11:8] <= spi_rx[3:0];
                            3'd6:    acc_z[7:0]  <= spi_rx;
                            3'd7:    acc_z[11:8] <= spi_rx[3:0];
                            default: ;
                        endcase
                    end
                    if (byte_idx == last_idx) begin
                        ph  <= TX_TAIL;
                        cnt <= TAIL_LAST;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
                TX_TAIL: if (cnt == '0) begin
                    ph  <= TX_GAP;
                    nCS <= 1'b1;
                    cnt <= GAP_LAST;
                end else begin
                    cnt <= cnt - 16'd1;
                end
                default: if (cnt == '0) ph <= TX_IDLE;
                         else           cnt <= cnt - 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_sync    <= '0;
            wait_cnt     <= '0;
            cfg_idx      <= '0;
            init_done    <= 1'b0;
            xdata        <= '0;
            ydata        <= '0;
            zdata        <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
        end else begin
            int1_sync    <= {int1_sync[0], int1};
            sample_valid <= 1'b0;

            if (state == ST_SOFT_RST && txn_done)          wait_cnt <= RST_WAIT_LAST;
            else if (state == ST_RST_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 16'd1;

            if (state != ST_CFG) cfg_idx <= '0;
            else if (txn_done)   cfg_idx <= cfg_idx + 2'd1;

            if (next_state == ST_IDLE)
                init_done <= 1'b0;
            else if (state == ST_CFG && txn_done && cfg_idx == 2'd2)
                init_done <= 1'b1;

            // Publish as nCS rises so the strobe coincides with the new data.
            if (is_read && txn_end) begin
                xdata        <= acc_x;
                ydata        <= acc_y;
                zdata        <= acc_z;
                sample_valid <= 1'b1;
                sample_count <= sample_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adxl362_host_ctrl.sv
// Directed bench for adxl362_host_ctrl with a behavioural ADXL362 SPI responder.
// Each task drives one scenario and checks against hand-computed values.
module tb_adxl362_host_ctrl;
    import adxl362_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        int1 = 1'b0;
    logic        miso_pin;
    logic        SCLK, MOSI, nCS;
    logic [11:0] xdata, ydata, zdata;
    logic        sample_valid, init_done, busy;
    logic [15:0] sample_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    // Device model state, owned by the monitor block below.
    logic [47:0] model_bytes = '0;
    logic [63:0] miso_sh = '0;
    logic [7:0]  mosi_sh = '0;
    logic [7:0]  mosi_q[$];
    int          rises_q[$];
    int          gap_q[$];
    int          mon_bits = 0, mon_rises = 0, frames = 0, cyc = 0, rise_cyc = 0, sv_bad = 0;
    logic        have_rise = 1'b0, ncs_prev = 1'b1, sclk_prev = 1'b0;

    always #5 clk = ~clk;
    assign miso_pin = miso_sh[63];

    adxl362_host_ctrl #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .int1(int1), .MISO(miso_pin),
        .SCLK(SCLK), .MOSI(MOSI), .nCS(nCS), .xdata(xdata), .ydata(ydata), .zdata(zdata),
        .sample_valid(sample_valid), .init_done(init_done), .busy(busy),
        .sample_count(sample_count)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sample_valid && !init_done) sv_bad = sv_bad + 1;
        if (ncs_prev && !nCS) begin
            mon_bits = 0;
            mon_rises = 0;
            miso_sh = {16'h0000, model_bytes};
            if (have_rise) gap_q.push_back(cyc - rise_cyc);
        end else if (!nCS && SCLK && !sclk_prev) begin
            mosi_sh = {mosi_sh[6:0], MOSI};
            mon_bits = mon_bits + 1;
            mon_rises = mon_rises + 1;
            miso_sh = {miso_sh[62:0], 1'b0};
            if (mon_bits == 8) begin
                mosi_q.push_back(mosi_sh);
                mon_bits = 0;
            end
        end
        if (!ncs_prev && nCS) begin
            frames = frames + 1;
            rises_q.push_back(mon_rises);
            rise_cyc = cyc;
            have_rise = 1'b1;
        end
        ncs_prev = nCS;
        sclk_prev = SCLK;
    end

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; int1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        checks++; if (nCS !== 1'b1) begin failures++; $display("FAIL reset_ncs got=%b exp=1", nCS); end
        checks++; if ({xdata, ydata, zdata} !== 36'h0) begin failures++; $display("FAIL reset_xyz got=%h exp=0", {xdata, ydata, zdata}); end
        checks++; if ({sample_valid, init_done, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {sample_valid, init_done, busy}); end
        checks++; if (sample_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", sample_count); end
    endtask

    // Releases reset with enable high and checks the whole configuration stream.
    task automatic test_init(input string tag);
        logic [7:0] exp_b [12] = '{8'h0A, 8'h1F, 8'h52, 8'h0A, 8'h2C, 8'h13,
                                   8'h0A, 8'h2A, 8'h01, 8'h0A, 8'h2D, 8'h02};
        logic [7:0] got;
        int b, fb, rb, gb, n, hi, min_gap;
        @(negedge clk);
        b = mosi_q.size(); fb = frames; rb = rises_q.size(); gb = gap_q.size();
        rst_n = 1'b1; enable = 1'b1;
        n = 0; hi = 0;
        while (!init_done && n < 4000) begin
            @(negedge clk); n++;
            if (nCS) hi++; else hi = 0;
        end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL %s init_done got=%b exp=1 (timeout)", tag, init_done); end
        checks++; if (hi < 16) begin failures++; $display("FAIL %s init_done_after_gap got=%0d exp>=16", tag, hi); end
        checks++; if (mosi_q.size() - b != 12) begin failures++; $display("FAIL %s init_byte_count got=%0d exp=12", tag, mosi_q.size() - b); end
        for (int i = 0; i < 12; i++) begin
            got = (b + i < mosi_q.size()) ? mosi_q[b + i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin failures++; $display("FAIL %s init_byte%0d got=%h exp=%h", tag, i, got, exp_b[i]); end
        end
        checks++; if (frames - fb != 4) begin failures++; $display("FAIL %s init_frames got=%0d exp=4", tag, frames - fb); end
        for (int i = rb; i < rises_q.size(); i++) begin
            checks++; if (rises_q[i] != 24) begin failures++; $display("FAIL %s init_frame_rises got=%0d exp=24", tag, rises_q[i]); end
        end
        min_gap = 1000000;
        for (int i = gb + 1; i < gap_q.size(); i++) if (gap_q[i] < min_gap) min_gap = gap_q[i];
        checks++; if (min_gap < 16) begin failures++; $display("FAIL %s init_gap got=%0d exp>=16", tag, min_gap); end
    endtask

    task automatic test_single_read;
        int b, n, sv;
        logic [7:0] got;
        model_bytes = {8'h23, 8'h01, 8'h85, 8'hFF, 8'hFF, 8'h07};
        b = mosi_q.size();
        int1 = 1'b1; repeat (4) @(negedge clk); int1 = 1'b0;
        n = 0;
        while (!sample_valid && n < 1500) begin @(negedge clk); n++; end
        exp_count = exp_count + 1;
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL read_valid got=%b exp=1 (timeout)", sample_valid); end
        checks++; if (xdata !== 12'h123) begin failures++; $display("FAIL read_x got=%h exp=123", xdata); end
        checks++; if (ydata !== 12'hF85) begin failures++; $display("FAIL read_y got=%h exp=f85", ydata); end
        checks++; if (zdata !== 12'h7FF) begin failures++; $display("FAIL read_z got=%h exp=7ff", zdata); end
        checks++; if (sample_count !== 16'(exp_count)) begin failures++; $display("FAIL read_count got=%0d exp=%0d", sample_count, exp_count); end
        sv = 1;
        repeat (150) begin @(negedge clk); if (sample_valid) sv++; end
        checks++; if (sv != 1) begin failures++; $display("FAIL read_pulses got=%0d exp=1", sv); end
        checks++; if (mosi_q.size() - b != 8) begin failures++; $display("FAIL read_bytes got=%0d exp=8", mosi_q.size() - b); end
        for (int i = 0; i < 8; i++) begin
            got = (b + i < mosi_q.size()) ? mosi_q[b + i] : 8'hxx;
            checks++;
            if (got !== (i == 0 ? 8'h0B : (i == 1 ? 8'h0E : 8'h00))) begin
                failures++; $display("FAIL read_byte%0d got=%h", i, got);
            end
        end
        checks++; if (rises_q[$] != 64) begin failures++; $display("FAIL read_rises got=%0d exp=64", rises_q[$]); end
    endtask

    task automatic test_back_to_back;
        int fb, rb, gb, n, sv, min_gap;
        model_bytes = {8'h00, 8'h58, 8'hFF, 8'hFF, 8'h01, 8'h00};
        fb = frames; rb = rises_q.size(); gb = gap_q.size();
        int1 = 1'b1;
        n = 0; sv = 0;
        while (sv < 10 && n < 8000) begin @(negedge clk); n++; if (sample_valid) sv++; end
        int1 = 1'b0;
        repeat (300) begin @(negedge clk); if (sample_valid) sv++; end
        exp_count = exp_count + 10;
        checks++; if (sv != 10) begin failures++; $display("FAIL b2b_pulses got=%0d exp=10", sv); end
        checks++; if (frames - fb != 10) begin failures++; $display("FAIL b2b_frames got=%0d exp=10", frames - fb); end
        checks++; if (sample_count !== 16'(exp_count)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", sample_count, exp_count); end
        checks++; if ({xdata, ydata, zdata} !== {12'h800, 12'hFFF, 12'h001}) begin failures++; $display("FAIL b2b_xyz got=%h exp=800fff001", {xdata, ydata, zdata}); end
        min_gap = 1000000;
        for (int i = gb; i < gap_q.size(); i++) if (gap_q[i] < min_gap) min_gap = gap_q[i];
        checks++; if (min_gap < 16) begin failures++; $display("FAIL b2b_gap got=%0d exp>=16", min_gap); end
        for (int i = rb; i < rises_q.size(); i++) begin
            checks++; if (rises_q[i] != 64) begin failures++; $display("FAIL b2b_rises got=%0d exp=64", rises_q[i]); end
        end
    endtask

    task automatic test_wrap;
        int n;
        model_bytes = {8'h34, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08};
        force dut.sample_count = 16'hFFFF;
        @(negedge clk);
        release dut.sample_count;
        int1 = 1'b1; repeat (4) @(negedge clk); int1 = 1'b0;
        n = 0;
        while (!sample_valid && n < 1500) begin @(negedge clk); n++; end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1 (timeout)", sample_valid); end
        checks++; if (sample_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", sample_count); end
        checks++; if ({xdata, zdata} !== {12'h234, 12'h800}) begin failures++; $display("FAIL wrap_xz got=%h exp=234800", {xdata, zdata}); end
        exp_count = 0;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        int n;
        int1 = 1'b1;
        n = 0;
        while (nCS && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        while (mon_rises < 20 && n < 4000) begin @(negedge clk); n++; end
        checks++; if (mon_rises != 20) begin failures++; $display("FAIL rst_mid_position got=%0d exp=20", mon_rises); end
        rst_n = 1'b0;
        #1;
        checks++; if ({nCS, SCLK, MOSI} !== 3'b100) begin failures++; $display("FAIL rst_mid_pins got=%b exp=100", {nCS, SCLK, MOSI}); end
        checks++; if ({xdata, ydata, zdata} !== 36'h0) begin failures++; $display("FAIL rst_mid_xyz got=%h exp=0", {xdata, ydata, zdata}); end
        checks++; if ({sample_count, sample_valid, init_done, busy} !== 19'h0) begin failures++; $display("FAIL rst_mid_status got=%h exp=0", {sample_count, sample_valid, init_done, busy}); end
        int1 = 1'b0;
        repeat (3) @(negedge clk);
        test_init("rerun");
    endtask

    task automatic test_enable_drop;
        int n, fb;
        model_bytes = {8'hBC, 8'hFA, 8'h00, 8'h00, 8'h01, 8'hF8};
        int1 = 1'b1;
        fb = frames;
        n = 0;
        while (nCS && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        while (mon_rises < 30 && n < 4000) begin @(negedge clk); n++; end
        enable = 1'b0;
        while (!sample_valid && n < 6000) begin @(negedge clk); n++; end
        exp_count = exp_count + 1;
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL endrop_valid got=%b exp=1 (timeout)", sample_valid); end
        checks++; if ({xdata, ydata, zdata} !== {12'hABC, 12'h000, 12'h801}) begin failures++; $display("FAIL endrop_xyz got=%h exp=abc000801", {xdata, ydata, zdata}); end
        checks++; if (sample_count !== 16'(exp_count)) begin failures++; $display("FAIL endrop_count got=%0d exp=%0d", sample_count, exp_count); end
        repeat (100) @(negedge clk);
        checks++; if (rises_q[$] != 64) begin failures++; $display("FAIL endrop_rises got=%0d exp=64", rises_q[$]); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL endrop_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        checks++; if ({init_done, busy} !== 2'b00) begin failures++; $display("FAIL endrop_flags got=%b exp=00", {init_done, busy}); end
        repeat (10) begin
            int1 = ~int1;
            repeat (30) @(negedge clk);
        end
        checks++; if (frames - fb != 1) begin failures++; $display("FAIL endrop_frames got=%0d exp=1", frames - fb); end
        checks++; if (sample_count !== 16'(exp_count)) begin failures++; $display("FAIL endrop_hold got=%0d exp=%0d", sample_count, exp_count); end
        checks++; if (sv_bad != 0) begin failures++; $display("FAIL valid_before_init got=%0d exp=0", sv_bad); end
    endtask

    initial begin
        test_reset();
        test_init("first");
        test_single_read();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
